// File: rtl/conv3x3_filter.sv
// ---------------------------------------------------------------------------
// conv3x3_filter
//
// 3x3 convolution stage for the RGB565-style pixel pipeline. One vertical
// 3-pixel column arrives per valid beat. The two previous columns are held
// locally, so each beat forms a 3x3 window, and one filtered pixel leaves per
// beat after a fixed latency of three cycles. There is no stall: valid and the
// h/v counts advance every cycle, so input gaps reappear at the output.
//
// Coefficients and the final shift live in two banks. Writes go to the
// shadow bank. A commit request swaps shadow into active at the next frame
// start (first valid beat with hcount==0 and vcount==0). The swap beat itself
// is already filtered with the shadow values.
//
// Pipeline:
//   S1  window assembly + 27 signed multiplies (3 channels x 9 taps)
//   S2  per-channel sum of 9 products, arithmetic right shift
//   S3  per-channel clamp to [0, 2^w-1] and repack into a pixel
//
// Optional feature (compile-time macro ABS_OUT_EN):
//   defined   - S3 takes the magnitude of a negative channel sum before the
//               upper clamp (edge-magnitude output for Sobel/Laplacian).
//   undefined - negative channel sums clamp to 0.
//
// Ports:
//   clk_in          clock
//   rst_n_in        asynchronous reset, active low
//   data_in         column: [2]=row above, [1]=centre row, [0]=row below
//   hcount_in       x of the newest column
//   vcount_in       y of the centre row
//   data_valid_in   column valid this cycle
//   cfg_we          shadow write strobe
//   cfg_addr        0..8 = coeff k (row*3+col), 9 = shift, 10..15 ignored
//   cfg_data        write data; shift uses bits [3:0], unsigned
//   cfg_commit      request an active<=shadow swap at the next frame start
//   cfg_pending_out swap requested, not yet applied
//   data_valid_out  output pixel valid
//   hcount_out      hcount_in delayed 3 cycles
//   vcount_out      vcount_in delayed 3 cycles
//   line_out        filtered pixel
// ---------------------------------------------------------------------------
module conv3x3_filter #(
  parameter int R_WIDTH      = 5,
  parameter int G_WIDTH      = 6,
  parameter int B_WIDTH      = 5,
  parameter int COEFF_WIDTH  = 8,
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [2:0][R_WIDTH+G_WIDTH+B_WIDTH-1:0] data_in,
  input  logic [HCOUNT_WIDTH-1:0]                 hcount_in,
  input  logic [VCOUNT_WIDTH-1:0]                 vcount_in,
  input  logic                                    data_valid_in,
  input  logic                                    cfg_we,
  input  logic [3:0]                              cfg_addr,
  input  logic [COEFF_WIDTH-1:0]                  cfg_data,
  input  logic                                    cfg_commit,
  output logic                                    cfg_pending_out,
  output logic                                    data_valid_out,
  output logic [HCOUNT_WIDTH-1:0]                 hcount_out,
  output logic [VCOUNT_WIDTH-1:0]                 vcount_out,
  output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]      line_out
);

  localparam int PIX_WIDTH = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int MAX_W     = (R_WIDTH > G_WIDTH) ?
                             ((R_WIDTH > B_WIDTH) ? R_WIDTH : B_WIDTH) :
                             ((G_WIDTH > B_WIDTH) ? G_WIDTH : B_WIDTH);
  // Channel is zero-extended by one bit so it multiplies as a signed value.
  localparam int PROD_W    = COEFF_WIDTH + MAX_W + 1;
  // Four guard bits cover the sum of nine products without overflow.
  localparam int SUM_W     = PROD_W + 4;

  localparam logic [COEFF_WIDTH-1:0] COEF_ONE      = {{(COEFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]             SHIFT_DEFAULT = 4'd4;
  localparam logic signed [SUM_W-1:0] SUM_ONE      = {{(SUM_W-1){1'b0}}, 1'b1};
  localparam logic signed [SUM_W-1:0] R_MAX        = (SUM_ONE <<< R_WIDTH) - SUM_ONE;
  localparam logic signed [SUM_W-1:0] G_MAX        = (SUM_ONE <<< G_WIDTH) - SUM_ONE;
  localparam logic signed [SUM_W-1:0] B_MAX        = (SUM_ONE <<< B_WIDTH) - SUM_ONE;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Reset kernel: 1-2-1 Gaussian, {1,2,1,2,4,2,1,2,1}.
  function automatic logic [COEFF_WIDTH-1:0] default_coef(input logic [3:0] k);
    logic [COEFF_WIDTH-1:0] c;
    case (k)
      4'd4:                    c = COEF_ONE << 2;
      4'd1, 4'd3, 4'd5, 4'd7:  c = COEF_ONE << 1;
      default:                 c = COEF_ONE;
    endcase
    return c;
  endfunction

  // Extract channel ch (0=R top bits, 1=G middle, 2=B bottom), zero-extended.
  function automatic logic [MAX_W-1:0] chan_of(input logic [PIX_WIDTH-1:0] pix,
                                               input logic [1:0]           ch);
    logic [MAX_W-1:0] v;
    v = {MAX_W{1'b0}};
    case (ch)
      2'd0:    v[R_WIDTH-1:0] = pix[PIX_WIDTH-1 -: R_WIDTH];
      2'd1:    v[G_WIDTH-1:0] = pix[B_WIDTH +: G_WIDTH];
      default: v[B_WIDTH-1:0] = pix[B_WIDTH-1:0];
    endcase
    return v;
  endfunction

  // Clamp a shifted channel sum into [0, max_v].
  function automatic logic signed [SUM_W-1:0] clamp_chan(input logic signed [SUM_W-1:0] s,
                                                          input logic signed [SUM_W-1:0] max_v);
    logic signed [SUM_W-1:0] mag;
`ifdef ABS_OUT_EN
    mag = s[SUM_W-1] ? -s : s;
`else
    mag = s[SUM_W-1] ? {SUM_W{1'b0}} : s;
`endif
    return (mag > max_v) ? max_v : mag;
  endfunction

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [2:0][PIX_WIDTH-1:0]      col0_q, col1_q;
  logic [2:0][2:0][PIX_WIDTH-1:0] win_s;            // [col][data_in row index]
  logic                           row_start_s;
  logic                           swap_s;

  logic [8:0][COEFF_WIDTH-1:0]    active_coef_q, active_coef_d;
  logic [8:0][COEFF_WIDTH-1:0]    shadow_coef_q, shadow_coef_d;
  logic [8:0][COEFF_WIDTH-1:0]    coef_sel_s;
  logic [3:0]                     active_shift_q, active_shift_d;
  logic [3:0]                     shadow_shift_q, shadow_shift_d;
  logic [3:0]                     shift_sel_s;
  logic                           pending_q, pending_d;

  logic signed [PROD_W-1:0]       prod_s [3][9];
  logic signed [PROD_W-1:0]       prod_q [3][9];
  logic [3:0]                     shift1_q;
  logic                           valid1_q;
  logic [HCOUNT_WIDTH-1:0]        hc1_q;
  logic [VCOUNT_WIDTH-1:0]        vc1_q;

  logic signed [SUM_W-1:0]        shifted_s [3];
  logic signed [SUM_W-1:0]        sum2_q [3];
  logic                           valid2_q;
  logic [HCOUNT_WIDTH-1:0]        hc2_q;
  logic [VCOUNT_WIDTH-1:0]        vc2_q;

  logic [PIX_WIDTH-1:0]           pix_s;
  logic [PIX_WIDTH-1:0]           line_q;
  logic                           valid3_q;
  logic [HCOUNT_WIDTH-1:0]        hc3_q;
  logic [VCOUNT_WIDTH-1:0]        vc3_q;

  // -------------------------------------------------------------------------
  // Window assembly and swap detection
  // -------------------------------------------------------------------------

  // Build the 3x3 window; at row start the new column is replicated leftwards.
  always_comb begin
    row_start_s = data_valid_in && (hcount_in == {HCOUNT_WIDTH{1'b0}});
    swap_s      = pending_q && row_start_s && (vcount_in == {VCOUNT_WIDTH{1'b0}});
    win_s[2]    = data_in;
    if (row_start_s) begin
      win_s[1] = data_in;
      win_s[0] = data_in;
    end else begin
      win_s[1] = col1_q;
      win_s[0] = col0_q;
    end
  end

  // Column history: advances only on valid beats, reloads at row start.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col0_q <= '0;
      col1_q <= '0;
    end else if (data_valid_in) begin
      col0_q <= row_start_s ? data_in : col1_q;
      col1_q <= data_in;
    end else begin
      col0_q <= col0_q;
      col1_q <= col1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Coefficient banks
  // -------------------------------------------------------------------------

  // Next-state for the banks and the pending flag.
  always_comb begin
    // Shadow writes read the registered bank, so a swap-cycle write stays in shadow.
    for (int k = 0; k < 9; k++) begin
      shadow_coef_d[k] = (cfg_we && (cfg_addr == 4'(k))) ? cfg_data : shadow_coef_q[k];
    end
    shadow_shift_d = (cfg_we && (cfg_addr == 4'd9)) ? cfg_data[3:0] : shadow_shift_q;
    if (swap_s) begin
      active_coef_d  = shadow_coef_q;
      active_shift_d = shadow_shift_q;
      pending_d      = 1'b0;
    end else begin
      active_coef_d  = active_coef_q;
      active_shift_d = active_shift_q;
      pending_d      = cfg_commit ? 1'b1 : pending_q;
    end
  end

  // The swap beat is filtered with the incoming (shadow) values.
  always_comb begin
    coef_sel_s  = swap_s ? shadow_coef_q  : active_coef_q;
    shift_sel_s = swap_s ? shadow_shift_q : active_shift_q;
  end

  // Bank and pending registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < 9; k++) begin
        active_coef_q[k] <= default_coef(4'(k));
        shadow_coef_q[k] <= default_coef(4'(k));
      end
      active_shift_q <= SHIFT_DEFAULT;
      shadow_shift_q <= SHIFT_DEFAULT;
      pending_q      <= 1'b0;
    end else begin
      active_coef_q  <= active_coef_d;
      shadow_coef_q  <= shadow_coef_d;
      active_shift_q <= active_shift_d;
      shadow_shift_q <= shadow_shift_d;
      pending_q      <= pending_d;
    end
  end

  // -------------------------------------------------------------------------
  // S1: multiply
  // -------------------------------------------------------------------------

  // 27 products; tap k = row*3+col with row 0 = row above (data_in[2]).
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          prod_s[ch][r*3+c] =
            PROD_W'($signed(coef_sel_s[r*3+c])) *
            PROD_W'($signed({1'b0, chan_of(win_s[c][2-r], 2'(ch))}));
        end
      end
    end
  end

  // S1 registers; the shift travels with its beat.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int k = 0; k < 9; k++) begin
          prod_q[ch][k] <= {PROD_W{1'b0}};
        end
      end
      shift1_q <= 4'd0;
      valid1_q <= 1'b0;
      hc1_q    <= {HCOUNT_WIDTH{1'b0}};
      vc1_q    <= {VCOUNT_WIDTH{1'b0}};
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int k = 0; k < 9; k++) begin
          prod_q[ch][k] <= prod_s[ch][k];
        end
      end
      shift1_q <= shift_sel_s;
      valid1_q <= data_valid_in;
      hc1_q    <= hcount_in;
      vc1_q    <= vcount_in;
    end
  end

  // -------------------------------------------------------------------------
  // S2: sum and shift
  // -------------------------------------------------------------------------

  // Sign-extended accumulation, then arithmetic right shift.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      logic signed [SUM_W-1:0] acc;
      acc = {SUM_W{1'b0}};
      for (int k = 0; k < 9; k++) begin
        acc = acc + SUM_W'(prod_q[ch][k]);
      end
      shifted_s[ch] = acc >>> shift1_q;
    end
  end

  // S2 registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < 3; ch++) begin
        sum2_q[ch] <= {SUM_W{1'b0}};
      end
      valid2_q <= 1'b0;
      hc2_q    <= {HCOUNT_WIDTH{1'b0}};
      vc2_q    <= {VCOUNT_WIDTH{1'b0}};
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        sum2_q[ch] <= shifted_s[ch];
      end
      valid2_q <= valid1_q;
      hc2_q    <= hc1_q;
      vc2_q    <= vc1_q;
    end
  end

  // -------------------------------------------------------------------------
  // S3: clamp and pack
  // -------------------------------------------------------------------------

  // Clamped values fit their channel width, so truncation is lossless.
  always_comb begin
    pix_s = {R_WIDTH'(clamp_chan(sum2_q[0], R_MAX)),
             G_WIDTH'(clamp_chan(sum2_q[1], G_MAX)),
             B_WIDTH'(clamp_chan(sum2_q[2], B_MAX))};
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_q   <= {PIX_WIDTH{1'b0}};
      valid3_q <= 1'b0;
      hc3_q    <= {HCOUNT_WIDTH{1'b0}};
      vc3_q    <= {VCOUNT_WIDTH{1'b0}};
    end else begin
      line_q   <= pix_s;
      valid3_q <= valid2_q;
      hc3_q    <= hc2_q;
      vc3_q    <= vc2_q;
    end
  end

  assign line_out        = line_q;
  assign data_valid_out  = valid3_q;
  assign hcount_out      = hc3_q;
  assign vcount_out      = vc3_q;
  assign cfg_pending_out = pending_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Self-checking bench for conv3x3_filter (default parameters, RGB 5/6/5).
// A behavioural model keeps the current row's columns in a queue and
// computes each output pixel with integer arithmetic from the kernel rules.
module tb_conv3x3_filter;

  typedef logic [2:0][15:0] col_t;
  typedef struct packed {
    logic        v;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [15:0] pix;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  col_t        data_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic        cfg_pending_out;
  logic        data_valid_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [15:0] line_out;

  conv3x3_filter dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .data_in         (data_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .data_valid_in   (data_valid_in),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .cfg_commit      (cfg_commit),
    .cfg_pending_out (cfg_pending_out),
    .data_valid_out  (data_valid_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .line_out        (line_out)
  );

  always #5 clk_in = ~clk_in;

  int   checks;
  int   errors;
  exp_t exp_q[$];
  col_t row_cols[$];
  int   m_active[9];
  int   m_shadow[9];
  int   m_ash, m_ssh;
  bit   m_pending;
  int   m_cu[9];
  int   m_shu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic col_t rcol();
    col_t c;
    c[0] = 16'($urandom);
    c[1] = 16'($urandom);
    c[2] = 16'($urandom);
    return c;
  endfunction

  // Reference convolution with integer arithmetic on the window w0(oldest)..w2.
  function automatic logic [15:0] conv(input col_t w0, input col_t w1, input col_t w2);
    col_t        w[3];
    int          wd[3];
    int          off[3];
    int          res[3];
    int          sum, v, s, mx;
    logic [15:0] px, t;
    w[0] = w0; w[1] = w1; w[2] = w2;
    wd  = '{5, 6, 5};
    off = '{11, 5, 0};
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          px  = w[c][2-r];           // row 0 is the row above
          t   = px >> off[ch];
          v   = int'(t) & ((1 << wd[ch]) - 1);
          sum = sum + m_cu[r*3+c] * v;
        end
      end
      s  = sum >>> m_shu;
      mx = (1 << wd[ch]) - 1;
`ifdef ABS_OUT_EN
      if (s < 0) s = -s;
`else
      if (s < 0) s = 0;
`endif
      if (s > mx) s = mx;
      res[ch] = s;
    end
    return 16'((res[0] << 11) | (res[1] << 5) | res[2]);
  endfunction

  task automatic m_reset();
    exp_t e;
    m_active  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    m_shadow  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    m_ash     = 4;
    m_ssh     = 4;
    m_pending = 1'b0;
    row_cols.delete();
    exp_q.delete();
    e = '0;
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, advance the model, check the output of 3 cycles ago.
  task automatic step(input bit v, input int hc, input int vc, input col_t col,
                      input bit we, input logic [3:0] addr, input logic [7:0] dat,
                      input bit commit);
    exp_t e;
    bit   swap;
    int   n;
    data_valid_in = v;
    hcount_in     = hc[10:0];
    vcount_in     = vc[9:0];
    data_in       = col;
    cfg_we        = we;
    cfg_addr      = addr;
    cfg_data      = dat;
    cfg_commit    = commit;

    swap = m_pending && v && (hc == 0) && (vc == 0);
    for (int k = 0; k < 9; k++) m_cu[k] = swap ? m_shadow[k] : m_active[k];
    m_shu = swap ? m_ssh : m_ash;
    e.v   = v;
    e.hc  = hc[10:0];
    e.vc  = vc[9:0];
    e.pix = 16'h0000;
    if (v) begin
      if (hc == 0) row_cols.delete();
      row_cols.push_back(col);
      n = row_cols.size();
      e.pix = conv((n >= 3) ? row_cols[n-3] : row_cols[0],
                   (n >= 2) ? row_cols[n-2] : row_cols[0],
                   row_cols[n-1]);
      if (n > 3) void'(row_cols.pop_front());
    end
    if (swap) begin
      m_active  = m_shadow;
      m_ash     = m_ssh;
      m_pending = 1'b0;
    end else if (commit) begin
      m_pending = 1'b1;
    end
    if (we) begin
      if (addr < 4'd9) m_shadow[addr] = int'($signed(dat));
      else if (addr == 4'd9) m_ssh = int'(dat[3:0]);
    end
    exp_q.push_back(e);

    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    chk("valid_out", 32'(data_valid_out), 32'(e.v));
    chk("hcount_out", 32'(hcount_out), 32'(e.hc));
    chk("vcount_out", 32'(vcount_out), 32'(e.vc));
    if (e.v) chk("line_out", 32'(line_out), 32'(e.pix));
    chk("pending", 32'(cfg_pending_out), 32'(m_pending));
  endtask

  task automatic beat(input bit v, input int hc, input int vc, input col_t col);
    step(v, hc, vc, col, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 0, 0, col_t'(48'h0));
  endtask

  initial begin
    int   sh[9];
    int   hc;
    bit   v;
    col_t flat10, g63, z, n63;

    checks = 0;
    errors = 0;
    rst_n_in = 1'b0;
    data_valid_in = 1'b0;
    data_in = '0;
    hcount_in = '0;
    vcount_in = '0;
    cfg_we = 1'b0;
    cfg_addr = 4'd0;
    cfg_data = 8'd0;
    cfg_commit = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", 32'(data_valid_out), 32'd0);
    chk("rst_line", 32'(line_out), 32'd0);
    chk("rst_hcount", 32'(hcount_out), 32'd0);
    chk("rst_vcount", 32'(vcount_out), 32'd0);
    chk("rst_pending", 32'(cfg_pending_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Flat field, Gaussian defaults
    for (int i = 0; i < 10; i++) beat(1'b1, i, 5, {3{16'hFFFF}});
    idle(3);

    // Left-edge replication
    beat(1'b1, 0, 6, {3{16'h8000}});
    beat(1'b1, 1, 6, {3{16'h0000}});
    idle(3);

    // Valid gaps 1,0,1,1,0 with garbage on the idle beats
    beat(1'b1, 0, 7, rcol());
    beat(1'b0, 1, 7, rcol());
    beat(1'b1, 1, 7, rcol());
    beat(1'b1, 2, 7, rcol());
    beat(1'b0, 3, 7, rcol());
    idle(3);

    // Leave a commit pending, fill the pipeline, then reset asynchronously
    step(1'b1, 0, 9, {3{16'hFFFF}}, 1'b0, 4'd0, 8'd0, 1'b1);
    for (int i = 1; i < 5; i++) beat(1'b1, i, 9, {3{16'hFFFF}});
    data_valid_in = 1'b0;
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("async_valid", 32'(data_valid_out), 32'd0);
    chk("async_line", 32'(line_out), 32'd0);
    chk("async_pending", 32'(cfg_pending_out), 32'd0);
    #1;
    rst_n_in = 1'b1;
    m_reset();
    for (int i = 0; i < 6; i++) beat(1'b1, i, 8, {3{16'hFFFF}});
    idle(3);

    // Sharpen kernel written mid-frame, committed, swapped at frame start
    sh = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    hc = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, hc, 200, rcol(), 1'b1, 4'(k), 8'(sh[k]), 1'b0);
      hc++;
    end
    step(1'b1, hc, 200, rcol(), 1'b1, 4'd9, 8'd0, 1'b0); hc++;
    step(1'b1, hc, 200, rcol(), 1'b0, 4'd0, 8'd0, 1'b1); hc++;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, hc, 200, rcol());
      hc++;
    end
    flat10 = {3{16'h0140}};
    g63    = {16'h0000, 16'h07E0, 16'h0000};
    z      = {3{16'h0000}};
    n63    = {16'h07E0, 16'h0000, 16'h07E0};
    for (int i = 0; i < 4; i++) beat(1'b1, i, 0, flat10);
    beat(1'b1, 0, 1, z);
    beat(1'b1, 1, 1, g63);
    beat(1'b1, 2, 1, z);
    beat(1'b1, 3, 1, z);
    // Negative sum: neighbours G=63, centre 0
    beat(1'b1, 0, 2, {3{16'h07E0}});
    beat(1'b1, 1, 2, n63);
    beat(1'b1, 2, 2, {3{16'h07E0}});
    beat(1'b1, 3, 2, {3{16'h07E0}});
    idle(3);

    // Randomised frames with random configuration traffic
    for (int f = 0; f < 4; f++) begin
      for (int row = 0; row < 3; row++) begin
        hc = 0;
        for (int b = 0; b < 14; b++) begin
          v = (hc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          step(v, hc, row, rcol(), ($urandom_range(0, 4) == 0), 4'($urandom),
               8'($urandom), ($urandom_range(0, 9) == 0));
          if (v) hc++;
        end
      end
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_filter.md
Name: conv3x3_filter

Overview:
Parametrised 3x3 convolution stage for the RGB pixel pipeline. Takes one vertical 3-pixel column per valid beat from the line buffer and outputs one filtered pixel per beat with a fixed 3-cycle latency. Coefficients and shift are programmable at runtime through a shadow bank that takes effect only at frame start. Reset defaults are the 1-2-1 Gaussian kernel with shift 4. Left-edge columns are replicated at the start of each row.

Parameters:
R_WIDTH, 5, red channel width; red occupies the top bits of the pixel.
G_WIDTH, 6, green channel width; green occupies the middle bits.
B_WIDTH, 5, blue channel width; blue occupies the bottom bits.
COEFF_WIDTH, 8, signed coefficient width.
HCOUNT_WIDTH, 11, width of hcount.
VCOUNT_WIDTH, 10, width of vcount.
(derived) PIX_WIDTH = R_WIDTH+G_WIDTH+B_WIDTH.

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous reset, active low
data_in  in  [2:0][PIX_WIDTH]  column: [2]=row above, [1]=centre row, [0]=row below
hcount_in  in  HCOUNT_WIDTH  x of the newest column
vcount_in  in  VCOUNT_WIDTH  y of the centre row
data_valid_in  in  1  column valid this cycle
cfg_we  in  1  shadow write strobe
cfg_addr  in  4  0..8 = coeff k (row*3+col), 9 = shift, 10..15 ignored
cfg_data  in  COEFF_WIDTH  write data; shift uses bits [3:0], unsigned
cfg_commit  in  1  request an active<=shadow swap at the next frame start
cfg_pending_out  out  1  swap requested, not yet applied
data_valid_out  out  1  output pixel valid
hcount_out  out  HCOUNT_WIDTH  hcount_in delayed 3 beats
vcount_out  out  VCOUNT_WIDTH  vcount_in delayed 3 beats
line_out  out  PIX_WIDTH  filtered pixel

Behaviour:
- Window: col 0 = oldest column, col 2 = newest column (data_in). Two column registers are updated only on data_valid_in.
- Row start, data_valid_in && hcount_in==0: all three window columns = data_in, and both column registers load data_in (clamp-to-edge).
- S1 (multiply): each channel is zero-extended and signed, then multiplied by its coefficient. Product width = COEFF_WIDTH+max channel width+1.
- S2 (sum): 9 products are summed at product width+4 (no overflow), then arithmetic right-shifted by the active shift.
- S3 (clamp): per channel, clamp to [0, 2^w-1] and pack into line_out.
- Latency: exactly 3 cycles from data_valid_in to data_valid_out. No stall. The valid bit and the h/v counts shift through the pipeline every cycle, so input gaps are reproduced at the output.
- Reset (asynchronous, takes effect immediately):
  - data_valid_out=0, line_out=0, hcount_out=0, vcount_out=0, cfg_pending_out=0.
  - Column registers and pipeline registers are cleared.
  - Active and shadow banks = {1,2,1,2,4,2,1,2,1}, shift=4.
- cfg_we writes the shadow bank only; the active bank never changes mid-frame.
- cfg_commit sets pending. Commit while already pending has no further effect.
- Swap cycle: first cycle with pending && data_valid_in && hcount_in==0 && vcount_in==0.
  - That beat's multiply already uses the shadow values (registered contents before this cycle's write).
  - Active <= shadow, pending clears on the next edge.
  - A cfg_we in the swap cycle lands in the shadow only.
- cfg_we and cfg_commit in the same cycle: the write is included in the later swap.

Optional Feature:
ABS_OUT_EN: when defined, S3 takes the magnitude of a negative channel sum before clamping to 2^w-1 (edge-magnitude output for Sobel/Laplacian kernels). When undefined, negative sums clamp to 0.

Test Plan:
- Reset defaults, flat field data_in all 16'hFFFF, hcount 0..9 -> data_valid_out rises 3 cycles after the first beat; line_out=16'hFFFF (R: 16*31>>4=31); hcount_out=0..9 in order.
- Edge replication: hcount_in=0, all rows 16'h8000, then hcount_in=1 all rows 0 -> out[hc0]=16'h8000 (R=16); out[hc1] R=(12*16)>>4=12 -> 16'h6000.
- Commit mid-frame: write sharpen {0,-1,0,-1,5,-1,0,-1,0}, shift 0, commit at vcount 200 -> cfg_pending_out=1 and Gaussian output continues; at the vcount0/hcount0 beat pending drops; flat G=10 -> G=10; centre G=63 with neighbours 0 -> G=63.
- Negative clamp: sharpen active, neighbours G=63, centre 0 -> G=0; with ABS_OUT_EN -> G=63 (|-252| clamped).
- Valid gaps: data_valid_in pattern 1,0,1,1,0 -> data_valid_out shows the same pattern delayed 3 cycles; column registers do not advance on the 0 beats.
- Async reset mid-stream: drop rst_n_in between edges with the pipeline full -> data_valid_out and line_out go 0 immediately with no clock; after release, a flat-field run matches Gaussian output and pending=0.
